// File: rtl/wb_copy_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_copy_master_pkg
// Purpose  : Shared constants and state encoding for the Wishbone block-copy
//            initiator (wb_copy_master) and its ack timer.
// Contents : WB_ADR_W   - Wishbone word-address width
//            WB_DAT_W   - Wishbone data width
//            WB_SEL_ALL - full-word byte select
//            ST_*       - state encodings, state_t enum built from them
// Revision : 1.0 - initial release
// ============================================================================
package wb_copy_master_pkg;

  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_REQ = 3'd1;
  localparam logic [2:0] ST_RD_GAP = 3'd2;
  localparam logic [2:0] ST_WR_REQ = 3'd3;
  localparam logic [2:0] ST_WR_GAP = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RD_REQ = ST_RD_REQ,
    S_RD_GAP = ST_RD_GAP,
    S_WR_REQ = ST_WR_REQ,
    S_WR_GAP = ST_WR_GAP,
    S_FIN    = ST_FIN
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_copy_master_ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_ack_timer
// Purpose  : Counts cycles spent waiting for a Wishbone ack. o_expired is
//            high during the TIMEOUT-th consecutive ack-less waiting cycle.
// Ports    : clk       - clock (rising edge)
//            rst_n     - asynchronous active-low reset
//            i_clear   - reload the counter to zero (outside request states)
//            i_wait    - a request is outstanding and no ack this cycle
//            o_expired - wait limit reached this cycle
// Revision : 1.0 - initial release
// ============================================================================
module wb_ack_timer #(
  parameter int TIMEOUT = 255   // must be >= 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // r_cnt holds the number of ack-less cycles already completed, so the
  // current cycle is the (r_cnt+1)-th one.
  assign o_expired = i_wait && (r_cnt == c_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_wait) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_copy_master
// Purpose  : Wishbone classic-cycle initiator that copies a block of 32-bit
//            words from src to dst, or fills dst with a constant pattern.
//            The bus (cyc) is held for the whole job.
// Ports    : wb_clk_i, wb_rst_ni           - clock, async active-low reset
//            start_i, fill_i               - job request and job type
//            src_adr_i, dst_adr_i, len_i   - job addresses and word count
//            pattern_i                     - fill value
//            busy_o, done_o, err_o         - job status
//            wbm_*                         - Wishbone initiator port
// Revision : 1.0 - initial release
// ============================================================================
module wb_copy_master
  import wb_copy_master_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                start_i,
  input  logic                fill_i,
  input  logic [WB_ADR_W-1:0] src_adr_i,
  input  logic [WB_ADR_W-1:0] dst_adr_i,
  input  logic [LEN_W-1:0]    len_i,
  input  logic [WB_DAT_W-1:0] pattern_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic                wbm_stb_o,
  output logic                wbm_cyc_o,
  input  logic                wbm_ack_i
);

  state_t              r_state, w_state_nx;
  logic [WB_ADR_W-1:0] r_src, w_src_nx;
  logic [WB_ADR_W-1:0] r_dst, w_dst_nx;
  logic [LEN_W-1:0]    r_rem, w_rem_nx;
  logic                r_fill, w_fill_nx;
  logic [WB_DAT_W-1:0] r_pattern, w_pattern_nx;
  logic [WB_DAT_W-1:0] r_rdata, w_rdata_nx;

  logic                w_err_nx, w_busy_nx, w_done_nx;
  logic                w_cyc_nx, w_stb_nx, w_we_nx;
  logic [WB_ADR_W-1:0] w_adr_nx;
  logic [WB_DAT_W-1:0] w_dat_nx;

  logic                w_is_req;
  logic                w_expired;

  assign wbm_sel_o = WB_SEL_ALL;

  // stb is high in every cycle of a request state, so this is also the
  // window in which an ack is honoured.
  assign w_is_req = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);

  wb_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .i_clear   (!w_is_req),
    .i_wait    (w_is_req && !wbm_ack_i),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nx   = r_state;
    w_src_nx     = r_src;
    w_dst_nx     = r_dst;
    w_rem_nx     = r_rem;
    w_fill_nx    = r_fill;
    w_pattern_nx = r_pattern;
    w_rdata_nx   = r_rdata;
    w_err_nx     = err_o;
    w_busy_nx    = busy_o;
    w_cyc_nx     = wbm_cyc_o;
    w_adr_nx     = wbm_adr_o;
    w_dat_nx     = wbm_dat_o;
    w_stb_nx     = 1'b0;
    w_we_nx      = 1'b0;
    w_done_nx    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_src_nx     = src_adr_i;
          w_dst_nx     = dst_adr_i;
          w_rem_nx     = len_i;
          w_fill_nx    = fill_i;
          w_pattern_nx = pattern_i;
          w_err_nx     = 1'b0;
          w_busy_nx    = 1'b1;
          if (len_i == '0)  w_state_nx = S_FIN;
          else if (fill_i)  w_state_nx = S_WR_REQ;
          else              w_state_nx = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (wbm_ack_i) begin
          w_rdata_nx = wbm_dat_i;
          w_state_nx = S_RD_GAP;
        end else if (w_expired) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_FIN;
        end
      end
      S_RD_GAP: w_state_nx = S_WR_REQ;
      S_WR_REQ: begin
        if (wbm_ack_i) begin
          w_state_nx = S_WR_GAP;
        end else if (w_expired) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_FIN;
        end
      end
      S_WR_GAP: begin
        w_rem_nx = r_rem - LEN_W'(1);
        w_src_nx = r_src + WB_ADR_W'(1);
        w_dst_nx = r_dst + WB_ADR_W'(1);
        if (w_rem_nx == '0) w_state_nx = S_FIN;
        else if (r_fill)    w_state_nx = S_WR_REQ;
        else                w_state_nx = S_RD_REQ;
      end
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    // Bus outputs are registered, so derive them from the state being
    // entered and the address/data values that go with it.
    case (w_state_nx)
      S_RD_REQ: begin
        w_cyc_nx = 1'b1;
        w_stb_nx = 1'b1;
        w_adr_nx = w_src_nx;
      end
      S_WR_REQ: begin
        w_cyc_nx = 1'b1;
        w_stb_nx = 1'b1;
        w_we_nx  = 1'b1;
        w_adr_nx = w_dst_nx;
        w_dat_nx = w_fill_nx ? w_pattern_nx : w_rdata_nx;
      end
      S_FIN: begin
        w_cyc_nx  = 1'b0;
        w_busy_nx = 1'b0;
        w_done_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_fill    <= 1'b0;
      r_pattern <= '0;
      r_rdata   <= '0;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_src     <= w_src_nx;
      r_dst     <= w_dst_nx;
      r_rem     <= w_rem_nx;
      r_fill    <= w_fill_nx;
      r_pattern <= w_pattern_nx;
      r_rdata   <= w_rdata_nx;
      err_o     <= w_err_nx;
      busy_o    <= w_busy_nx;
      done_o    <= w_done_nx;
      wbm_cyc_o <= w_cyc_nx;
      wbm_stb_o <= w_stb_nx;
      wbm_we_o  <= w_we_nx;
      wbm_adr_o <= w_adr_nx;
      wbm_dat_o <= w_dat_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_copy_master
// Purpose  : Self-checking bench for wb_copy_master against a BRAM-like
//            responder that acks in the same cycle as the strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_copy_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        start_i, fill_i;
  logic [29:0] src_adr_i, dst_adr_i;
  logic [15:0] len_i;
  logic [31:0] pattern_i;
  logic        busy_o, done_o, err_o;
  logic [29:0] wbm_adr_o;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;

  logic        ack_en;
  logic [31:0] mem [1024];

  typedef struct packed {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
  } txn_t;
  txn_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  assign wbm_ack_i = ack_en & wbm_cyc_o & wbm_stb_o;
  assign wbm_dat_i = mem[wbm_adr_o[9:0]];

  wb_copy_master #(.LEN_W(16), .TIMEOUT(255)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start_i   (start_i),
    .fill_i    (fill_i),
    .src_adr_i (src_adr_i),
    .dst_adr_i (dst_adr_i),
    .len_i     (len_i),
    .pattern_i (pattern_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Preloaded source words at 0x10..0x13.
  function automatic logic [31:0] pre_word(input int k);
    return 32'h1234_5600 + 32'(k) * 32'h0101_0101;
  endfunction

  task automatic push_copy(input logic [29:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      sb_q.push_back('{we: 1'b0, adr: 30'h10 + 30'(i), dat: 32'h0});
      sb_q.push_back('{we: 1'b1, adr: dst + 30'(i), dat: pre_word(i)});
    end
  endtask

  task automatic push_fill(input logic [29:0] dst, input int len, input logic [31:0] pat);
    for (int i = 0; i < len; i++)
      sb_q.push_back('{we: 1'b1, adr: dst + 30'(i), dat: pat});
  endtask

  // Responder memory and transaction monitor.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[16 + i] = pre_word(i);
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_ni && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        txn_t e;
        check("sb_expected", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("txn_we", 64'(wbm_we_o), 64'(e.we));
          check("txn_adr", 64'(wbm_adr_o), 64'(e.adr));
          if (e.we) check("txn_dat", 64'(wbm_dat_o), 64'(e.dat));
        end
        if (wbm_we_o) mem[wbm_adr_o[9:0]] = wbm_dat_o;
      end
    end
  end

  // cycles: 1 = cycle with start_i high; the cycle after the sampling edge is 2.
  task automatic run_job(input logic fill, input logic [29:0] src, input logic [29:0] dst,
                         input logic [15:0] len, input logic [31:0] pat, input logic glitch,
                         output int cycles, output int stbc, output logic cyc_seen);
    logic got;
    int   busy_gaps;
    @(negedge wb_clk_i);
    fill_i = fill; src_adr_i = src; dst_adr_i = dst; len_i = len; pattern_i = pat;
    start_i = 1'b1;
    cycles = 1; stbc = 0; cyc_seen = 1'b0; got = 1'b0; busy_gaps = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge wb_clk_i);
      #1;
      cycles++;
      if (glitch && cycles == 3) begin
        start_i = 1'b1; fill_i = 1'b0; dst_adr_i = 30'h55; len_i = 16'd7;
      end else begin
        start_i = 1'b0;
      end
      if (wbm_stb_o) stbc++;
      if (wbm_cyc_o) cyc_seen = 1'b1;
      if (done_o) got = 1'b1;
      else if (!busy_o) busy_gaps++;
    end
    start_i = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    if (len != 16'd0) check("busy_during_job", 64'(busy_gaps), 64'd0);
    check("fin_cyc_busy", {62'd0, wbm_cyc_o, busy_o}, 64'd0);
    @(posedge wb_clk_i);
    #1;
    check("done_one_cycle", 64'(done_o), 64'd0);
  endtask

  initial begin
    int   cyc, stbc;
    logic cyc_seen, seen;
    wb_rst_ni = 1'b0; start_i = 1'b0; fill_i = 1'b0; src_adr_i = '0; dst_adr_i = '0;
    len_i = '0; pattern_i = '0; ack_en = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ctrl", {58'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o, done_o, err_o}, 64'd0);
    check("rst_adr", 64'(wbm_adr_o), 64'd0);
    check("rst_dat", 64'(wbm_dat_o), 64'd0);
    check("rst_sel", 64'(wbm_sel_o), 64'hF);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    // Copy 4 words 0x10 -> 0x100.
    push_copy(30'h100, 4);
    run_job(1'b0, 30'h10, 30'h100, 16'd4, 32'h0, 1'b0, cyc, stbc, cyc_seen);
    check("copy_cycles", 64'(cyc), 64'd18);
    check("copy_err", 64'(err_o), 64'd0);
    for (int k = 0; k < 4; k++) check("copy_mem", 64'(mem[256 + k]), 64'(pre_word(k)));
    check("copy_sb_drained", 64'(sb_q.size()), 64'd0);

    // Fill 3 words at 0x200.
    push_fill(30'h200, 3, 32'hDEADBEEF);
    run_job(1'b1, 30'h0, 30'h200, 16'd3, 32'hDEADBEEF, 1'b0, cyc, stbc, cyc_seen);
    check("fill_cycles", 64'(cyc), 64'd8);
    for (int k = 0; k < 3; k++) check("fill_mem", 64'(mem[512 + k]), 64'hDEADBEEF);
    check("fill_sb_drained", 64'(sb_q.size()), 64'd0);

    // Zero length.
    run_job(1'b0, 30'h10, 30'h120, 16'd0, 32'h0, 1'b0, cyc, stbc, cyc_seen);
    check("zero_cycles", 64'(cyc), 64'd2);
    check("zero_no_cyc", 64'(cyc_seen), 64'd0);
    check("zero_err", 64'(err_o), 64'd0);

    // Timeout on the first read.
    ack_en = 1'b0;
    run_job(1'b0, 30'h20, 30'h300, 16'd3, 32'h0, 1'b0, cyc, stbc, cyc_seen);
    check("timeout_stb_cycles", 64'(stbc), 64'd255);
    check("timeout_err", 64'(err_o), 64'd1);
    ack_en = 1'b1;

    // A following good job clears err_o.
    push_fill(30'h210, 1, 32'hCAFE_F00D);
    run_job(1'b1, 30'h0, 30'h210, 16'd1, 32'hCAFE_F00D, 1'b0, cyc, stbc, cyc_seen);
    check("recover_err", 64'(err_o), 64'd0);
    check("recover_cycles", 64'(cyc), 64'd4);
    check("recover_mem", 64'(mem[528]), 64'hCAFE_F00D);

    // Address wrap with a second start issued mid-job.
    push_fill(30'h3FFF_FFFF, 2, 32'h5A5A_A5A5);
    run_job(1'b1, 30'h0, 30'h3FFF_FFFF, 16'd2, 32'h5A5A_A5A5, 1'b1, cyc, stbc, cyc_seen);
    check("wrap_cycles", 64'(cyc), 64'd6);
    check("wrap_mem_top", 64'(mem[1023]), 64'h5A5A_A5A5);
    check("wrap_mem_zero", 64'(mem[0]), 64'h5A5A_A5A5);
    check("wrap_sb_drained", 64'(sb_q.size()), 64'd0);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("glitch_ignored_idle", {62'd0, busy_o, wbm_cyc_o}, 64'd0);

    // Reset asserted while parked in WR_REQ.
    ack_en = 1'b0;
    @(negedge wb_clk_i);
    fill_i = 1'b1; dst_adr_i = 30'h300; len_i = 16'd2; pattern_i = 32'h1111_2222;
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("pre_rst_wr_req", {60'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o}, 64'hF);
    #2 wb_rst_ni = 1'b0;
    #1;
    check("rst_async_drop", {61'd0, wbm_cyc_o, wbm_stb_o, busy_o}, 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge wb_clk_i);
      #1;
      if (done_o) seen = 1'b1;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    ack_en = 1'b1;

    push_copy(30'h140, 4);
    run_job(1'b0, 30'h10, 30'h140, 16'd4, 32'h0, 1'b0, cyc, stbc, cyc_seen);
    check("post_rst_cycles", 64'(cyc), 64'd18);
    for (int k = 0; k < 4; k++) check("post_rst_mem", 64'(mem[320 + k]), 64'(pre_word(k)));
    check("post_rst_sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
